// File: rtl/fwrisc_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word reads on the instruction
// bus, reassembles RV32C-aligned instructions and presents one per emit.
module fwrisc_fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] iaddr,
    output logic        ivalid,
    input  logic [31:0] idata,
    input  logic        iready,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_valid_f,
    output logic [31:0] instr_f,
    output logic        instr_c_f,
    output logic [31:0] pc_f
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned HLEN = 16;
    localparam logic [XLEN-1:0] RESET_PC = RESET_VECTOR & ~XLEN'(1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REQ_HI,
        OUT
    } state_t;

    state_t            state, state_d;
    logic [XLEN-1:0]   pc, pc_d;
    logic              ivalid_d;
    logic [XLEN-1:0]   iaddr_d;
    logic              fetch_valid_d;
    logic [XLEN-1:0]   instr_d;
    logic              instr_c_d;
    logic [XLEN-1:0]   pc_f_d;
    logic              hbuf_valid, hbuf_valid_d;
    logic [XLEN-1:0]   hbuf_addr, hbuf_addr_d;
    logic [HLEN-1:0]   hbuf_data, hbuf_data_d;
    logic [HLEN-1:0]   lo_half, lo_half_d;
    logic              discard, discard_d;

    logic [HLEN-1:0]   hw;
    logic              hbuf_hit;
    logic [XLEN-1:0]   pc_plus2;
    logic [XLEN-1:0]   pc_plus4;

    assign hw       = pc[1] ? idata[31:16] : idata[15:0];
    assign hbuf_hit = hbuf_valid && pc[1] && (hbuf_addr == pc);
    assign pc_plus2 = pc + XLEN'(2);
    assign pc_plus4 = pc + XLEN'(4);

    // State and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            ivalid        <= 1'b0;
            iaddr         <= '0;
            fetch_valid_f <= 1'b0;
            instr_f       <= '0;
            instr_c_f     <= 1'b0;
            pc_f          <= '0;
            hbuf_valid    <= 1'b0;
            hbuf_addr     <= '0;
            hbuf_data     <= '0;
            lo_half       <= '0;
            discard       <= 1'b0;
        end else begin
            state         <= state_d;
            pc            <= pc_d;
            ivalid        <= ivalid_d;
            iaddr         <= iaddr_d;
            fetch_valid_f <= fetch_valid_d;
            instr_f       <= instr_d;
            instr_c_f     <= instr_c_d;
            pc_f          <= pc_f_d;
            hbuf_valid    <= hbuf_valid_d;
            hbuf_addr     <= hbuf_addr_d;
            hbuf_data     <= hbuf_data_d;
            lo_half       <= lo_half_d;
            discard       <= discard_d;
        end
    end

    // Next state: redirect first, then draining a discarded request, then the FSM
    always_comb begin
        state_d       = state;
        pc_d          = pc;
        ivalid_d      = ivalid;
        iaddr_d       = iaddr;
        fetch_valid_d = fetch_valid_f;
        instr_d       = instr_f;
        instr_c_d     = instr_c_f;
        pc_f_d        = pc_f;
        hbuf_valid_d  = hbuf_valid;
        hbuf_addr_d   = hbuf_addr;
        hbuf_data_d   = hbuf_data;
        lo_half_d     = lo_half;
        discard_d     = discard;

        if (redirect_valid) begin
            pc_d          = redirect_pc & ~XLEN'(1);
            fetch_valid_d = 1'b0;
            hbuf_valid_d  = 1'b0;
            if (ivalid && !iready) begin
                // Bus must keep its request; the data is dropped on completion
                discard_d = 1'b1;
            end else begin
                ivalid_d  = 1'b0;
                discard_d = 1'b0;
                state_d   = IDLE;
            end
        end else if (discard) begin
            if (iready) begin
                ivalid_d  = 1'b0;
                discard_d = 1'b0;
                state_d   = IDLE;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (hbuf_hit) begin
                        if (hbuf_data[1:0] != 2'b11) begin
                            fetch_valid_d = 1'b1;
                            instr_d       = {16'h0, hbuf_data};
                            instr_c_d     = 1'b1;
                            pc_f_d        = pc;
                            state_d       = OUT;
                        end else begin
                            lo_half_d = hbuf_data;
                            ivalid_d  = 1'b1;
                            iaddr_d   = {pc_plus2[31:2], 2'b00};
                            state_d   = REQ_HI;
                        end
                    end else begin
                        ivalid_d = 1'b1;
                        iaddr_d  = {pc[31:2], 2'b00};
                        state_d  = REQ;
                    end
                end
                REQ: begin
                    if (iready) begin
                        ivalid_d = 1'b0;
                        if (hw[1:0] != 2'b11) begin
                            fetch_valid_d = 1'b1;
                            instr_d       = {16'h0, hw};
                            instr_c_d     = 1'b1;
                            pc_f_d        = pc;
                            state_d       = OUT;
                            if (!pc[1]) begin
                                hbuf_valid_d = 1'b1;
                                hbuf_addr_d  = pc_plus2;
                                hbuf_data_d  = idata[31:16];
                            end
                        end else if (!pc[1]) begin
                            fetch_valid_d = 1'b1;
                            instr_d       = idata;
                            instr_c_d     = 1'b0;
                            pc_f_d        = pc;
                            state_d       = OUT;
                        end else begin
                            // Upper half of a misaligned 32-bit instruction lives in the next word
                            lo_half_d = hw;
                            ivalid_d  = 1'b1;
                            iaddr_d   = {pc_plus2[31:2], 2'b00};
                            state_d   = REQ_HI;
                        end
                    end
                end
                REQ_HI: begin
                    if (iready) begin
                        ivalid_d      = 1'b0;
                        fetch_valid_d = 1'b1;
                        instr_d       = {idata[15:0], lo_half};
                        instr_c_d     = 1'b0;
                        pc_f_d        = pc;
                        hbuf_valid_d  = 1'b1;
                        hbuf_addr_d   = pc_plus4;
                        hbuf_data_d   = idata[31:16];
                        state_d       = OUT;
                    end
                end
                OUT: begin
                    if (!stall) begin
                        pc_d          = instr_c_f ? pc_plus2 : pc_plus4;
                        fetch_valid_d = 1'b0;
                        state_d       = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fwrisc_fetch_stage.sv
// Testbench for fwrisc_fetch_stage: directed corner cases, a vector table and
// a randomized run against a program-order instruction model.
module tb_fwrisc_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] iaddr;
    logic        ivalid;
    logic [31:0] idata;
    logic        iready;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_valid_f;
    logic [31:0] instr_f;
    logic        instr_c_f;
    logic [31:0] pc_f;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [256];
    logic [31:0] xq [$];

    fwrisc_fetch_stage dut (
        .clock          (clock),
        .reset          (reset),
        .iaddr          (iaddr),
        .ivalid         (ivalid),
        .idata          (idata),
        .iready         (iready),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_valid_f  (fetch_valid_f),
        .instr_f        (instr_f),
        .instr_c_f      (instr_c_f),
        .pc_f           (pc_f)
    );

    always #5 clock = ~clock;

    // Memory aliases every 1 KiB; garbage on idata when no completion
    assign idata = iready ? mem[iaddr[9:2]] : 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] epc;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] instr;
        logic        c;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timeout", name);
    endtask

    function automatic logic [15:0] half_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Instruction at a PC in program order, straight from memory contents
    task automatic ref_decode(input logic [31:0] pc, output logic [31:0] ins, output logic c);
        logic [15:0] h0;
        h0 = half_at(pc);
        if (h0[1:0] != 2'b11) begin
            ins = {16'h0, h0};
            c   = 1'b1;
        end else begin
            ins = {half_at(pc + 32'd2), h0};
            c   = 1'b0;
        end
    endtask

    // One clock; records completions and checks bus hold/alignment rules
    task automatic step();
        logic        pv, pr, prst;
        logic [31:0] pa;
        pv   = ivalid;
        pr   = iready;
        pa   = iaddr;
        prst = reset;
        if (ivalid && iready) xq.push_back(iaddr);
        @(posedge clock);
        #1;
        if (prst && reset && pv && !pr) begin
            chk("bus_hold_ivalid", 32'(ivalid), 32'd1);
            chk("bus_hold_iaddr", iaddr, pa);
        end
        if (reset && ivalid) chk("iaddr_align", 32'(iaddr[1:0]), 32'd0);
    endtask

    task automatic wait_fv(input string name);
        int n;
        n = 0;
        while (!fetch_valid_f && n < 64) begin
            step();
            n++;
        end
        if (!fetch_valid_f) timeout(name);
    endtask

    task automatic next_emit(input string name);
        int n;
        n = 0;
        while (fetch_valid_f && n < 64) begin
            step();
            n++;
        end
        wait_fv(name);
    endtask

    task automatic wait_ivalid(input string name);
        int n;
        n = 0;
        while (!ivalid && n < 64) begin
            step();
            n++;
        end
        if (!ivalid) timeout(name);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
        xq.delete();
    endtask

    initial begin
        logic [31:0] sv_instr, sv_pc, exp_pc, ei, tmp;
        logic        ec, pfv, pst, prd;
        logic [31:0] prpc;
        int          since, emits;

        tbl[0] = '{32'h0000_0300, 32'h0000_0300, 32'h00A0_0093, 32'h0000_0013, 32'h00A0_0093, 1'b0};
        tbl[1] = '{32'h0000_0302, 32'h0000_0302, 32'h4501_0000, 32'h0000_0013, 32'h0000_4501, 1'b1};
        tbl[2] = '{32'h0000_0302, 32'h0000_0302, 32'h0093_0000, 32'hFFFF_0013, 32'h0013_0093, 1'b0};
        tbl[3] = '{32'h0000_0300, 32'h0000_0300, 32'h1234_8001, 32'h0000_0013, 32'h0000_8001, 1'b1};
        tbl[4] = '{32'h0000_0300, 32'h0000_0300, 32'hABCD_0002, 32'h0000_0013, 32'h0000_0002, 1'b1};
        tbl[5] = '{32'h0000_0300, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0000_0013, 32'hDEAD_BEEF, 1'b0};
        tbl[6] = '{32'h0000_0302, 32'h0000_0302, 32'hBEEF_1234, 32'h5678_ABCD, 32'hABCD_BEEF, 1'b0};
        tbl[7] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h0093_0000, 32'h0000_0013, 32'h0013_0093, 1'b0};
        tbl[8] = '{32'h0000_0305, 32'h0000_0304, 32'h0000_4085, 32'h0000_0013, 32'h0000_4085, 1'b1};

        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
        mem[0] = 32'h00A0_0093;
        reset          = 1'b0;
        iready         = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset values
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ivalid", 32'(ivalid), 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_fv", 32'(fetch_valid_f), 32'd0);
        chk("rst_instr", instr_f, 32'd0);
        chk("rst_c", 32'(instr_c_f), 32'd0);
        chk("rst_pc_f", pc_f, 32'd0);

        // First fetch after reset release
        iready = 1'b1;
        reset  = 1'b1;
        step();
        chk("t1_ivalid", 32'(ivalid), 32'd1);
        chk("t1_iaddr", iaddr, 32'h8000_0000);
        step();
        chk("t1_fv", 32'(fetch_valid_f), 32'd1);
        chk("t1_instr", instr_f, 32'h00A0_0093);
        chk("t1_c", 32'(instr_c_f), 32'd0);
        chk("t1_pc_f", pc_f, 32'h8000_0000);
        step();
        step();
        chk("t1_next_ivalid", 32'(ivalid), 32'd1);
        chk("t1_next_iaddr", iaddr, 32'h8000_0004);

        // Two compressed instructions from one word
        mem[0] = 32'h0001_4501;
        mem[1] = 32'h0000_0013;
        redirect_to(32'h0);
        wait_fv("t2_emit0");
        chk("t2_instr0", instr_f, 32'h0000_4501);
        chk("t2_c0", 32'(instr_c_f), 32'd1);
        chk("t2_pc0", pc_f, 32'h0);
        next_emit("t2_emit1");
        chk("t2_instr1", instr_f, 32'h0000_0001);
        chk("t2_c1", 32'(instr_c_f), 32'd1);
        chk("t2_pc1", pc_f, 32'h2);
        chk("t2_nbus", 32'(xq.size()), 32'd1);
        step();
        wait_ivalid("t2_req");
        chk("t2_iaddr", iaddr, 32'h4);

        // Misaligned 32-bit after a compressed one
        mem[0] = 32'h0093_4501;
        mem[1] = 32'h0000_0013;
        redirect_to(32'h0);
        wait_fv("t3_emit0");
        chk("t3_instr0", instr_f, 32'h0000_4501);
        next_emit("t3_emit1");
        chk("t3_instr1", instr_f, 32'h0013_0093);
        chk("t3_c1", 32'(instr_c_f), 32'd0);
        chk("t3_pc1", pc_f, 32'h2);
        chk("t3_nbus", 32'(xq.size()), 32'd2);
        if (xq.size() == 2) chk("t3_hi_addr", xq[1], 32'h4);

        // Stall holds the output
        mem[0] = 32'h00A0_0093;
        mem[1] = 32'h0010_0113;
        redirect_to(32'h0);
        wait_fv("t4_emit0");
        stall    = 1'b1;
        sv_instr = instr_f;
        sv_pc    = pc_f;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_fv_held", 32'(fetch_valid_f), 32'd1);
            chk("t4_instr_held", instr_f, sv_instr);
            chk("t4_pc_held", pc_f, sv_pc);
            chk("t4_no_req", 32'(ivalid), 32'd0);
        end
        stall = 1'b0;
        next_emit("t4_emit1");
        chk("t4_pc_adv", pc_f, 32'h4);
        chk("t4_instr1", instr_f, 32'h0010_0113);

        // Redirect while a request is stuck; stale data must be dropped
        mem[16] = 32'h0000_4085;
        mem[64] = 32'h0050_0293;
        redirect_to(32'h40);
        iready = 1'b0;
        wait_ivalid("t5_req");
        chk("t5_iaddr0", iaddr, 32'h40);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        chk("t5_hold1", iaddr, 32'h40);
        step();
        chk("t5_hold2", iaddr, 32'h40);
        step();
        chk("t5_hold3", iaddr, 32'h40);
        chk("t5_fv_none", 32'(fetch_valid_f), 32'd0);
        iready = 1'b1;
        step();
        chk("t5_no_stale", 32'(fetch_valid_f), 32'd0);
        wait_ivalid("t5_req2");
        chk("t5_iaddr1", iaddr, 32'h100);
        wait_fv("t5_emit");
        chk("t5_pc_f", pc_f, 32'h100);
        chk("t5_instr", instr_f, 32'h0050_0293);

        // Vector table: redirect to a PC and check the first instruction
        for (int i = 0; i < 9; i++) begin
            mem[tbl[i].epc[9:2]] = tbl[i].w0;
            tmp = tbl[i].epc + 32'd4;
            mem[tmp[9:2]] = tbl[i].w1;
            redirect_to(tbl[i].rpc);
            wait_fv("tbl_emit");
            chk($sformatf("tbl%0d_instr", i), instr_f, tbl[i].instr);
            chk($sformatf("tbl%0d_c", i), 32'(instr_c_f), 32'(tbl[i].c));
            chk($sformatf("tbl%0d_pc", i), pc_f, tbl[i].epc);
        end

        // Reset asserted while waiting on the upper half
        mem[0] = 32'h0093_4501;
        mem[1] = 32'h0000_0013;
        redirect_to(32'h2);
        begin
            int n;
            n = 0;
            while (!(ivalid && iaddr == 32'h4) && n < 64) begin
                step();
                n++;
            end
            if (!(ivalid && iaddr == 32'h4)) timeout("t6_reach_req_hi");
        end
        iready = 1'b0;
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("t6_ivalid", 32'(ivalid), 32'd0);
        chk("t6_iaddr", iaddr, 32'd0);
        chk("t6_fv", 32'(fetch_valid_f), 32'd0);
        chk("t6_instr", instr_f, 32'd0);
        chk("t6_c", 32'(instr_c_f), 32'd0);
        chk("t6_pc_f", pc_f, 32'd0);
        @(posedge clock);
        #1;
        reset  = 1'b1;
        iready = 1'b1;
        wait_ivalid("t6_restart");
        chk("t6_iaddr_rv", iaddr, 32'h8000_0000);
        wait_fv("t6_emit");
        chk("t6_pc_rv", pc_f, 32'h8000_0000);
        chk("t6_instr_rv", instr_f, 32'h0000_4501);

        // Randomized run against the program-order model
        for (int i = 0; i < 256; i++) begin
            logic [15:0] lo, hi;
            lo = 16'($urandom());
            hi = 16'($urandom());
            if ($urandom_range(0, 1) == 1) lo[1:0] = 2'b11;
            if ($urandom_range(0, 1) == 1) hi[1:0] = 2'b11;
            mem[i] = {hi, lo};
        end
        exp_pc = 32'h0000_0010;
        redirect_to(exp_pc);
        since = 0;
        emits = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            iready         = ($urandom_range(0, 9) < 7);
            stall          = fetch_valid_f && ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 39) == 0);
            redirect_pc    = $urandom();
            pfv  = fetch_valid_f;
            pst  = stall;
            prd  = redirect_valid;
            prpc = redirect_pc;
            step();
            if (prd) begin
                exp_pc = prpc & ~32'h1;
            end else if (pfv && !pst) begin
                ref_decode(exp_pc, ei, ec);
                exp_pc = exp_pc + (ec ? 32'd2 : 32'd4);
            end
            if (fetch_valid_f) begin
                ref_decode(exp_pc, ei, ec);
                chk("rand_pc", pc_f, exp_pc);
                chk("rand_instr", instr_f, ei);
                chk("rand_c", 32'(instr_c_f), 32'(ec));
                since = 0;
                emits++;
            end else begin
                since++;
            end
            if (since > 200) begin
                timeout("rand_progress");
                break;
            end
        end
        redirect_valid = 1'b0;
        stall          = 1'b0;
        chk("rand_emits", 32'(emits > 200), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
